// File: rtl/updown_counter_mod_pkg.sv
// counter_pkg: shared constants and elaboration-time parameter checks for
// the up/down counter family.
//   MODE_WRAP / MODE_SAT : boundary behaviour selectors
//   params_ok()          : 1 when WIDTH/MAX_VAL/PRESCALE form a legal set
package counter_pkg;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // MAX_VAL must fit in WIDTH bits and be nonzero; prescaler needs >= 1.
  function automatic bit params_ok(int width, longint max_val, int prescale);
    longint lim;
    lim = (longint'(1) << width) - 1;
    return (width >= 1) && (max_val >= 1) && (max_val <= lim) && (prescale >= 1);
  endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// updown_counter_mod_if: control/status bundle of the up/down counter.
//   master : drives enable, up_down, step, load, load_value, clear_flag
//   slave  : drives count_out, wrap_pulse, overflow, at_min, at_max
interface updown_counter_mod_if #(parameter int WIDTH = 8);
  logic             enable;
  logic             up_down;
  logic [WIDTH-1:0] step;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear_flag;
  logic [WIDTH-1:0] count_out;
  logic             wrap_pulse;
  logic             overflow;
  logic             at_min;
  logic             at_max;

  modport master (
    output enable, up_down, step, load, load_value, clear_flag,
    input  count_out, wrap_pulse, overflow, at_min, at_max
  );

  modport slave (
    input  enable, up_down, step, load, load_value, clear_flag,
    output count_out, wrap_pulse, overflow, at_min, at_max
  );
endinterface

// File: rtl/updown_counter_mod_prescaler.sv
// tick_prescaler: counts enabled cycles 0..PRESCALE-1 and raises tick
// (combinational) on the enabled cycle that closes a period.
//   CLOCK, reset : clock, async active-high reset
//   enable       : advance the count; value holds while low
//   clear        : synchronous restart at 0 (wins over enable)
//   tick         : enable && count == PRESCALE-1
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (tick)   cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: up/down counter over 0..MAX_VAL with clamped step,
// wrap or saturate at the bounds, built-in prescaler and synchronous load.
//   CLOCK, reset : clock, async active-high reset
//   bus (slave)  : enable/up_down/step/load/load_value/clear_flag in,
//                  count_out/wrap_pulse/overflow registered out,
//                  at_min/at_max decoded from count_out
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 255,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic                 CLOCK,
  input  logic                 reset,
  updown_counter_mod_if.slave  bus
);
  generate
    if (!params_ok(WIDTH, longint'(MAX_VAL), PRESCALE)) begin : g_bad_params
      $error("updown_counter_mod: illegal WIDTH/MAX_VAL/PRESCALE");
    end
  endgenerate

  localparam bit             SAT_MODE = (SATURATE != 0);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MAX_VAL + 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             overflow_q, overflow_d;

  logic             tick;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] count_step;
  logic             bnd_event;
  logic             fire;

  // Load restarts the prescaler so the next step needs a full period.
  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .CLOCK  (CLOCK),
    .reset  (reset),
    .enable (bus.enable),
    .clear  (bus.load),
    .tick   (tick)
  );

  // Next count for a tick; one extra bit keeps count+step from overflowing.
  always_comb begin
    step_eff   = (bus.step > MAX_W) ? MAX_W : bus.step;
    sum        = {1'b0, count_q} + {1'b0, step_eff};
    count_step = count_q;
    bnd_event  = 1'b0;
    if (step_eff != '0) begin
      if (bus.up_down) begin
        if (sum <= {1'b0, MAX_W}) begin
          count_step = sum[WIDTH-1:0];
        end else begin
          bnd_event  = 1'b1;
          count_step = (SAT_MODE == MODE_SAT) ? MAX_W : WIDTH'(sum - MOD_W);
        end
      end else begin
        if (step_eff <= count_q) begin
          count_step = count_q - step_eff;
        end else begin
          bnd_event  = 1'b1;
          count_step = (SAT_MODE == MODE_SAT) ? '0
                     : WIDTH'({1'b0, count_q} + MOD_W - {1'b0, step_eff});
        end
      end
    end
  end

  // Load beats a coincident tick; an event beats a coincident clear_flag.
  always_comb begin
    count_d = count_q;
    fire    = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_value > MAX_W) ? MAX_W : bus.load_value;
    end else if (tick) begin
      count_d = count_step;
      fire    = bnd_event;
    end
    wrap_pulse_d = fire;
    overflow_d   = fire | (overflow_q & ~bus.clear_flag);
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      wrap_pulse_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      wrap_pulse_q <= wrap_pulse_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.count_out  = count_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.overflow   = overflow_q;
  assign bus.at_min     = (count_q == '0);
  assign bus.at_max     = (count_q == MAX_W);
endmodule
